contador_display_7seg: RTL and testbench

CONTADOR_DISPLAY_7SEG -- requirements
Module: contador_display_7seg

---
 rtl/display_pkg.sv | 28 ++
 rtl/hex_a_7seg.sv | 13 +
 rtl/contador_display_7seg.sv | 118 +++++++++++
 tb/tb_contador_display_7seg.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared segment definitions for the multiplexed hex display.
// Segment vectors are {g,f,e,d,c,b,a}, active-low.
package display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t SEG_TABLE [16] = '{
        7'b1000000,  // 0
        7'b1111001,  // 1
        7'b0100100,  // 2
        7'b0110000,  // 3
        7'b0011001,  // 4
        7'b0010010,  // 5
        7'b0000010,  // 6
        7'b1111000,  // 7
        7'b0000000,  // 8
        7'b0010000,  // 9
        7'b0001000,  // A
        7'b0000011,  // b
        7'b1000110,  // C
        7'b0100001,  // d
        7'b0000110,  // E
        7'b0001110   // F
    };

endpackage

// File: rtl/hex_a_7seg.sv
// Combinational nibble-to-segment decoder (active-low segments).
module hex_a_7seg
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output seg_t       seg
);

    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/contador_display_7seg.sv
// Multiplexed N-digit hex display driver with frame-synchronous double buffering.
// Define CONTADOR_DISPLAY_BLANK_ZEROS_EN to blank leading-zero digits (digit 0 always shown).
module contador_display_7seg
    import display_pkg::*;
#(
    parameter int unsigned N_DIGITS    = 8,
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*N_DIGITS-1:0]   value_in,
    input  logic                    load,
    output logic [N_DIGITS-1:0]     an,
    output seg_t                    seg,
    output logic                    frame_tick
);

    localparam int unsigned PW = $clog2(REFRESH_DIV);
    localparam int unsigned IW = $clog2(N_DIGITS);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*N_DIGITS-1:0] staging_q, staging_d;
    logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
    logic                  pending_q, pending_d;
    logic [N_DIGITS-1:0]   an_q, an_d;
    seg_t                  seg_q, seg_d;
    logic                  frame_tick_q;

    logic                  step;
    logic                  wrap;
    logic [3:0]            cur_nibble;
    seg_t                  dec_seg;
    logic                  blank_cur;

    assign step = (presc_q == PRESC_LAST);
    assign wrap = step && (idx_q == IDX_LAST);

    always_comb begin
        presc_d   = step ? '0 : presc_q + 1'b1;
        idx_d     = idx_q;
        if (step) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
        staging_d = staging_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        // Shadow only changes at the wrap so a frame never mixes old and new digits.
        if (wrap && pending_q) begin
            shadow_d  = staging_q;
            pending_d = 1'b0;
        end
        if (load) begin
            staging_d = value_in;
            pending_d = 1'b1;
        end
    end

    assign cur_nibble = shadow_q[4*idx_q +: 4];

    hex_a_7seg u_dec (
        .nibble (cur_nibble),
        .seg    (dec_seg)
    );

`ifdef CONTADOR_DISPLAY_BLANK_ZEROS_EN
    logic [N_DIGITS-1:0] blank_mask;
    logic                zero_above;

    // Walk from the top digit down; a digit is blank while every nibble at or above it is zero.
    always_comb begin
        blank_mask = '0;
        zero_above = 1'b1;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_above    = zero_above && (shadow_q[4*k +: 4] == 4'h0);
            blank_mask[k] = zero_above && (k != 0);
        end
    end

    assign blank_cur = blank_mask[idx_q];
`else
    assign blank_cur = 1'b0;
`endif

    always_comb begin
        an_d  = ~(N_DIGITS'(1) << idx_q);
        seg_d = blank_cur ? SEG_BLANK : dec_seg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q      <= '0;
            idx_q        <= '0;
            staging_q    <= '0;
            shadow_q     <= '0;
            pending_q    <= 1'b0;
            an_q         <= '1;
            seg_q        <= SEG_BLANK;
            frame_tick_q <= 1'b0;
        end else begin
            presc_q      <= presc_d;
            idx_q        <= idx_d;
            staging_q    <= staging_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            frame_tick_q <= wrap;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_contador_display_7seg.sv
// Directed bench for contador_display_7seg with N_DIGITS=4, REFRESH_DIV=4 (16-cycle frame).
module tb_contador_display_7seg;

    logic        clk;
    logic        reset;
    logic [15:0] value_in;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_tick;

    int vectors;
    int errors;

    contador_display_7seg #(
        .N_DIGITS    (4),
        .REFRESH_DIV (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .value_in   (value_in),
        .load       (load),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [6:0] hex_pat(input logic [3:0] n);
        case (n)
            4'h0: hex_pat = 7'b1000000;
            4'h1: hex_pat = 7'b1111001;
            4'h2: hex_pat = 7'b0100100;
            4'h3: hex_pat = 7'b0110000;
            4'h4: hex_pat = 7'b0011001;
            4'h5: hex_pat = 7'b0010010;
            4'h6: hex_pat = 7'b0000010;
            4'h7: hex_pat = 7'b1111000;
            4'h8: hex_pat = 7'b0000000;
            4'h9: hex_pat = 7'b0010000;
            4'hA: hex_pat = 7'b0001000;
            4'hB: hex_pat = 7'b0000011;
            4'hC: hex_pat = 7'b1000110;
            4'hD: hex_pat = 7'b0100001;
            4'hE: hex_pat = 7'b0000110;
            default: hex_pat = 7'b0001110;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int d);
        logic [15:0] sh;
        sh = v >> (4 * d);
`ifdef CONTADOR_DISPLAY_BLANK_ZEROS_EN
        if (d != 0 && sh == 16'h0000) return 7'b1111111;
`endif
        return hex_pat(sh[3:0]);
    endfunction

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (!seen) begin
            $display("FAIL wait_tick: frame_tick=%b after 40 cycles, required a pulse", frame_tick);
            errors++;
        end
    endtask

    // Starts just after a frame_tick sample; checks one full frame, optionally injecting loads.
    task automatic run_frame(input string name, input logic [15:0] shown,
                             input int at1, input logic [15:0] v1,
                             input int at2, input logic [15:0] v2);
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_ft;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            e_an  = ~(4'b0001 << (i / 4));
            e_seg = exp_seg(shown, i / 4);
            e_ft  = (i == 15);
            vectors++;
            if (an !== e_an || seg !== e_seg || frame_tick !== e_ft) begin
                $display("FAIL %s cyc%0d: an=%b seg=%b tick=%b, required an=%b seg=%b tick=%b",
                         name, i, an, seg, frame_tick, e_an, e_seg, e_ft);
                errors++;
            end
            if (i == at1) begin
                load = 1'b1; value_in = v1;
            end else if (i == at2) begin
                load = 1'b1; value_in = v2;
            end else begin
                load = 1'b0;
            end
        end
        load = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0; load = 1'b0; value_in = 16'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || frame_tick !== 1'b0) begin
            $display("FAIL reset_hold: an=%b seg=%b tick=%b, required an=1111 seg=1111111 tick=0",
                     an, seg, frame_tick);
            errors++;
        end
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (an !== 4'b1110 || seg !== 7'b1000000) begin
            $display("FAIL reset_release: an=%b seg=%b, required an=1110 seg=1000000", an, seg);
            errors++;
        end
        n = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an !== 4'b1110) break;
            n++;
        end
        vectors++;
        if (n != 4 || an !== 4'b1101) begin
            $display("FAIL first_step: held=%0d an=%b, required held=4 an=1101", n, an);
            errors++;
        end
    endtask

    task automatic test_free_run();
        wait_tick();
        run_frame("free_run", 16'h0000, -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_load_mid();
        run_frame("load_hold", 16'h0000, 5, 16'h12AF, -1, 16'h0);
        run_frame("load_show", 16'h12AF, -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_last_wins();
        run_frame("last_wins_hold", 16'h12AF, 2, 16'h1111, 9, 16'h2222);
        run_frame("last_wins_show", 16'h2222, -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_wrap_load();
        // Index 14 drives load into the cycle whose closing edge is the wrap.
        run_frame("wrap_hold", 16'h2222, 3, 16'h3333, 14, 16'h00F0);
        run_frame("wrap_old", 16'h3333, -1, 16'h0, -1, 16'h0);
        run_frame("wrap_new", 16'h00F0, -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_blank();
        run_frame("blank_load5", 16'h00F0, 4, 16'h0005, -1, 16'h0);
        run_frame("blank_show5", 16'h0005, 7, 16'h0000, -1, 16'h0);
        run_frame("blank_show0", 16'h0000, -1, 16'h0, -1, 16'h0);
    endtask

    task automatic test_reset_mid();
        run_frame("pre_reset", 16'h0000, 3, 16'h7777, -1, 16'h0);
        run_frame("pre_reset_show", 16'h7777, 6, 16'h4321, -1, 16'h0);
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (an !== 4'b1111 || seg !== 7'b1111111 || frame_tick !== 1'b0) begin
            $display("FAIL reset_mid: an=%b seg=%b tick=%b, required an=1111 seg=1111111 tick=0",
                     an, seg, frame_tick);
            errors++;
        end
        reset = 1'b1;
        wait_tick();
        run_frame("post_reset_a", 16'h0000, -1, 16'h0, -1, 16'h0);
        run_frame("post_reset_b", 16'h0000, -1, 16'h0, -1, 16'h0);
    endtask

    initial begin
        vectors = 0;
        errors  = 0;
        test_reset();
        test_free_run();
        test_load_mid();
        test_last_wins();
        test_wrap_load();
        test_blank();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
